// File: rtl/psum_accumulator_pkg.sv
// Shared widths, FSM state encoding and the lane saturation helper for psum_accumulator.
package psum_accumulator_pkg;

  localparam int TN            = 16;
  localparam int FEATURE_WIDTH = 16;
  localparam int ACC_WIDTH     = 32;
  localparam int TILE_W        = 8;
  localparam int SHIFT_W       = 5;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (FEATURE_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);

  typedef enum logic [1:0] {
    PSUM_IDLE,
    PSUM_ACCUM,
    PSUM_SCALE,
    PSUM_OUTPUT
  } psum_state_t;

  // Clamp a shifted accumulator value into the signed feature range.
  function automatic logic signed [FEATURE_WIDTH-1:0] sat_fw(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[FEATURE_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[FEATURE_WIDTH-1:0];
    end
    return v[FEATURE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Adder-tree input and output-buffer handshake signals of psum_accumulator.
interface psum_accumulator_if;
  import psum_accumulator_pkg::*;

  logic                          in_valid;
  logic [TN*FEATURE_WIDTH-1:0]   in_sum;
  logic                          in_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic [TN*FEATURE_WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/psum_accumulator_lane.sv
// One output-channel lane: accumulator, arithmetic shift, saturation and optional ReLU.
// Defining PSUM_RELU_EN forces negative saturated results to zero.
module psum_lane
  import psum_accumulator_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     add_en,
  input  logic                     scale_en,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic [FEATURE_WIDTH-1:0] in_lane,
  output logic [FEATURE_WIDTH-1:0] out_lane
);

  logic signed [ACC_WIDTH-1:0]     acc;
  logic signed [ACC_WIDTH-1:0]     shifted;
  logic signed [FEATURE_WIDTH-1:0] sat_val;
  logic signed [FEATURE_WIDTH-1:0] final_val;

  // The accumulator wraps silently; overflow is the caller's concern.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + {{(ACC_WIDTH-FEATURE_WIDTH){in_lane[FEATURE_WIDTH-1]}}, in_lane};
    end
  end

  assign shifted = acc >>> shift;
  assign sat_val = sat_fw(shifted);

`ifdef PSUM_RELU_EN
  assign final_val = sat_val[FEATURE_WIDTH-1] ? '0 : sat_val;
`else
  assign final_val = sat_val;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_lane <= '0;
    end else if (scale_en) begin
      out_lane <= final_val;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates Tn-lane tile sums over cfg_tile_num tiles, then scales/saturates into one output word.
// Optional fused ReLU in every lane when PSUM_RELU_EN is defined.
module psum_accumulator
  import psum_accumulator_pkg::*;
(
  input  logic                fast_clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TILE_W-1:0]   cfg_tile_num,
  input  logic [SHIFT_W-1:0]  cfg_shift,
  psum_accumulator_if.slave   bus,
  output logic                done,
  output logic                err_overrun
);

  psum_state_t state;
  psum_state_t state_next;

  logic [TILE_W-1:0]           tile_num;
  logic [TILE_W-1:0]           cnt;
  logic [SHIFT_W-1:0]          shift;
  logic                        start_take;
  logic                        add_en;
  logic                        scale_en;
  logic                        out_valid_q;
  logic [TN*FEATURE_WIDTH-1:0] out_word;

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      state <= PSUM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start_take = 1'b0;
    add_en     = 1'b0;
    scale_en   = 1'b0;
    done       = 1'b0;
    case (state)
      PSUM_IDLE: begin
        if (start) begin
          start_take = 1'b1;
          state_next = PSUM_ACCUM;
        end
      end
      PSUM_ACCUM: begin
        if (bus.in_valid) begin
          add_en = 1'b1;
          if (cnt == tile_num - TILE_W'(1)) begin
            state_next = PSUM_SCALE;
          end
        end
      end
      PSUM_SCALE: begin
        scale_en   = 1'b1;
        state_next = PSUM_OUTPUT;
      end
      PSUM_OUTPUT: begin
        if (bus.out_ready) begin
          done       = 1'b1;
          state_next = PSUM_IDLE;
        end
      end
      default: state_next = PSUM_IDLE;
    endcase
  end

  // A zero tile count behaves as a single tile so the FSM can always leave ACCUM.
  always_ff @(posedge fast_clk) begin
    if (rst) begin
      tile_num    <= TILE_W'(1);
      cnt         <= '0;
      shift       <= '0;
      out_valid_q <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (start_take) begin
        tile_num <= (cfg_tile_num == '0) ? TILE_W'(1) : cfg_tile_num;
        shift    <= cfg_shift;
        cnt      <= '0;
      end else if (add_en) begin
        cnt <= cnt + TILE_W'(1);
      end

      if (scale_en) begin
        out_valid_q <= 1'b1;
      end else if (done) begin
        out_valid_q <= 1'b0;
      end

      if (bus.in_valid && (state != PSUM_ACCUM)) begin
        err_overrun <= 1'b1;
      end else if (start_take) begin
        err_overrun <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state == PSUM_ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_word;

  for (genvar i = 0; i < TN; i++) begin : g_lane
    psum_lane u_lane (
      .clk      (fast_clk),
      .rst      (rst),
      .clear    (start_take),
      .add_en   (add_en),
      .scale_en (scale_en),
      .shift    (shift),
      .in_lane  (bus.in_sum[i*FEATURE_WIDTH +: FEATURE_WIDTH]),
      .out_lane (out_word[i*FEATURE_WIDTH +: FEATURE_WIDTH])
    );
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomised self-checking bench for psum_accumulator against a floor-divide/clamp reference model.
module tb_psum_accumulator;
  import psum_accumulator_pkg::*;

  localparam int W = TN * FEATURE_WIDTH;

  logic               fast_clk = 1'b0;
  logic               rst;
  logic               start;
  logic [TILE_W-1:0]  cfg_tile_num;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               done;
  logic               err_overrun;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] tile_data [0:15];

  psum_accumulator_if bus ();

  psum_accumulator dut (
    .fast_clk     (fast_clk),
    .rst          (rst),
    .start        (start),
    .cfg_tile_num (cfg_tile_num),
    .cfg_shift    (cfg_shift),
    .bus          (bus.slave),
    .done         (done),
    .err_overrun  (err_overrun)
  );

  always #5 fast_clk = ~fast_clk;

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  // Reference: exact integer sum, wrap to the accumulator width, floor division by 2^shift, clamp.
  function automatic logic [W-1:0] model_word(input int n, input int sh);
    logic [W-1:0]                    word;
    logic signed [FEATURE_WIDTH-1:0] v;
    logic signed [ACC_WIDTH-1:0]     a32;
    longint acc, a, d, q, maxv, minv;
    word = '0;
    maxv = (longint'(1) << (FEATURE_WIDTH - 1)) - 1;
    minv = -maxv - 1;
    for (int lane = 0; lane < TN; lane++) begin
      acc = 0;
      for (int t = 0; t < n; t++) begin
        v = tile_data[t][lane*FEATURE_WIDTH +: FEATURE_WIDTH];
        acc = acc + longint'(v);
      end
      a32 = acc[ACC_WIDTH-1:0];
      a = longint'(a32);
      d = longint'(1) << sh;
      q = a / d;
      if ((a % d != 0) && (a < 0)) q = q - 1;
      if (q > maxv) q = maxv;
      if (q < minv) q = minv;
`ifdef PSUM_RELU_EN
      if (q < 0) q = 0;
`endif
      word[lane*FEATURE_WIDTH +: FEATURE_WIDTH] = q[FEATURE_WIDTH-1:0];
    end
    return word;
  endfunction

  task automatic fill_random(input int n);
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < W / 32; k++) begin
        tile_data[t][k*32 +: 32] = $urandom;
      end
    end
  endtask

  task automatic run_job(input int cfg_n, input int sh, input int stall, input bit overrun_in_stall,
                         input bit start_with_valid, input bit start_mid, input bit start_on_accept,
                         input bit gaps, input string tag);
    int n;
    logic [W-1:0] exp;
    n   = (cfg_n == 0) ? 1 : cfg_n;
    exp = model_word(n, sh);

    cfg_tile_num = TILE_W'(cfg_n);
    cfg_shift    = SHIFT_W'(sh);
    start        = 1'b1;
    if (start_with_valid) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = ~tile_data[0];
    end
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b0;

    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s in_ready_accum: got %b want 1", tag, bus.in_ready);
    end
    total++;
    if (err_overrun !== start_with_valid) begin
      bad++;
      $display("[TB] FAIL %s err_after_start: got %b want %b", tag, err_overrun, start_with_valid);
    end

    for (int t = 0; t < n; t++) begin
      if (gaps) repeat ($urandom_range(2)) tick();
      bus.in_valid = 1'b1;
      bus.in_sum   = tile_data[t];
      if (start_mid && t == n - 1) begin
        start        = 1'b1;
        cfg_tile_num = TILE_W'(7);
      end
      tick();
      bus.in_valid = 1'b0;
      start        = 1'b0;
    end

    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s scale_cycle: out_valid=%b in_ready=%b want 0 0", tag, bus.out_valid, bus.in_ready);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
      bad++;
      $display("[TB] FAIL %s result: valid=%b data=%h want valid=1 data=%h", tag, bus.out_valid, bus.out_data, exp);
    end

    for (int s = 0; s < stall; s++) begin
      if (overrun_in_stall && s == stall / 2) begin
        bus.in_valid = 1'b1;
        bus.in_sum   = {W/32{$urandom}};
      end
      tick();
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp || done !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s stall_hold: valid=%b done=%b data=%h want 1 0 %h", tag, bus.out_valid, done, bus.out_data, exp);
      end
    end
    if (overrun_in_stall) begin
      total++;
      if (err_overrun !== 1'b1) begin
        bad++;
        $display("[TB] FAIL %s err_overrun_stall: got %b want 1", tag, err_overrun);
      end
    end

    bus.out_ready = 1'b1;
    if (start_on_accept) start = 1'b1;
    #1;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s done_on_accept: got %b want 1", tag, done);
    end
    tick();
    bus.out_ready = 1'b0;
    start         = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s after_accept: valid=%b done=%b in_ready=%b want 0 0 0", tag, bus.out_valid, done, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    start         = 1'b0;
    cfg_tile_num  = '0;
    cfg_shift     = '0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || done !== 1'b0 || err_overrun !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: valid=%b data=%h done=%b err=%b in_ready=%b want all 0",
               bus.out_valid, bus.out_data, done, err_overrun, bus.in_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    fill_random(3);
    tile_data[0][15:0] = 16'd100;
    tile_data[1][15:0] = 16'd200;
    tile_data[2][15:0] = 16'hFFCE;
    run_job(3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "basic");
    total++;
    if (bus.out_data[15:0] !== 16'd250) begin
      bad++;
      $display("[TB] FAIL basic_lane0: got %0d want 250", $signed(bus.out_data[15:0]));
    end
  endtask

  task automatic test_shift();
    logic [15:0] want;
`ifdef PSUM_RELU_EN
    want = 16'h0000;
`else
    want = 16'hFFFE;
`endif
    fill_random(1);
    tile_data[0][63:48] = 16'hFFF9;
    run_job(1, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "shift");
    total++;
    if (bus.out_data[63:48] !== want) begin
      bad++;
      $display("[TB] FAIL shift_lane3: got %h want %h", bus.out_data[63:48], want);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] want_neg;
`ifdef PSUM_RELU_EN
    want_neg = 16'h0000;
`else
    want_neg = 16'h8000;
`endif
    fill_random(2);
    tile_data[0][31:16] = 16'd30000;
    tile_data[1][31:16] = 16'd30000;
    tile_data[0][47:32] = 16'h8AD0;
    tile_data[1][47:32] = 16'h8AD0;
    run_job(2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "saturation");
    total++;
    if (bus.out_data[31:16] !== 16'h7FFF || bus.out_data[47:32] !== want_neg) begin
      bad++;
      $display("[TB] FAIL sat_lanes: lane1=%h lane2=%h want 7fff %h", bus.out_data[31:16], bus.out_data[47:32], want_neg);
    end
  endtask

  task automatic test_stall();
    fill_random(2);
    run_job(2, 1, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_reset_mid();
    fill_random(4);
    cfg_tile_num = TILE_W'(4);
    cfg_shift    = '0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = tile_data[t];
      tick();
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || done !== 1'b0 || err_overrun !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid: valid=%b data=%h done=%b err=%b in_ready=%b want all 0",
               bus.out_valid, bus.out_data, done, err_overrun, bus.in_ready);
    end
    fill_random(1);
    run_job(1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_relu_sign();
    logic [15:0] want;
`ifdef PSUM_RELU_EN
    want = 16'h0000;
`else
    want = 16'hFFFB;
`endif
    tile_data[0]       = '0;
    tile_data[0][15:0] = 16'hFFFB;
    run_job(1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "relu");
    total++;
    if (bus.out_data[15:0] !== want) begin
      bad++;
      $display("[TB] FAIL relu_lane0: got %h want %h", bus.out_data[15:0], want);
    end
  endtask

  task automatic test_start_overrun();
    fill_random(1);
    run_job(0, 3, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "start_overrun");
  endtask

  task automatic test_back_to_back();
    int n, sh, st, eff;
    for (int j = 0; j < 20; j++) begin
      n   = $urandom_range(6);
      eff = (n == 0) ? 1 : n;
      sh  = $urandom_range(31);
      st  = $urandom_range(3);
      fill_random(eff);
      run_job(n, sh, st, 1'b0, 1'b0, (eff >= 2) && ($urandom_range(1) == 1), 1'b0, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_relu_sign();
    test_start_overrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
